instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the program ROM.
- Drives the ROM address and select/enable lines, waits out the ROM read latency and captures the 16-bit instruction word.
- Hands the word to the decoder over a valid/ready handshake.
- Supports jump redirection and halt detection.

Parameters:
- ADDR_W, 8, ROM address / PC width
- DATA_W, 16, instruction width
- ROM_LAT, 2, ROM read latency in clk cycles; ROM data is stable ROM_LAT cycles after the address is first presented
- RESET_PC, 8'h01, PC value after reset

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  address to ROM
- rom_cs  out  1  ROM chip select
- rom_oe  out  1  ROM output enable
- rom_data  in  DATA_W  ROM read data
- instr  out  DATA_W  captured instruction
- instr_pc  out  ADDR_W  address the instruction was fetched from
- instr_valid  out  1  instr/instr_pc hold a word not yet accepted
- instr_ready  in  1  decoder accepts the word
- jump_en  in  1  redirect fetch, one-cycle pulse
- jump_addr  in  ADDR_W  redirect target
- halted  out  1  fetch stopped on halt word

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high; sampled on the rising edge and overrides everything else.
  - Reset values: pc=RESET_PC, state=ISSUE, rom_addr=RESET_PC, rom_cs=0, rom_oe=0, instr=16'hFFFF, instr_pc=0, instr_valid=0, halted=0, wait counter=0.
- State ISSUE:
  - rom_addr=pc, rom_cs=1, rom_oe=1, held constant for ROM_LAT+1 consecutive cycles; counter runs 0..ROM_LAT.
  - At the rising edge ending the cycle with counter==ROM_LAT: instr<=rom_data, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, so 8'hFF wraps to 8'h00), instr_valid<=1, go to HOLD.
  - Fetch latency from entering ISSUE to instr_valid=1 is ROM_LAT+1 cycles (3 at default).
- State HOLD:
  - rom_cs=0 and rom_oe=0; rom_addr keeps the last value.
  - instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.
  - On instr_valid&&instr_ready: instr_valid<=0, counter<=0, go to ISSUE.
  - No prefetch. Throughput is one word per ROM_LAT+2 cycles with ready tied high.
- State HALT:
  - rom_cs=0, rom_oe=0, instr_valid=0, halted=1.
  - Left only via jump_en or rst.
- Jump (any state, below rst in priority):
  - pc<=jump_addr, counter<=0, state<=ISSUE, halted<=0.
  - Any in-flight ISSUE is abandoned and its rom_data discarded.
  - An un-accepted HOLD word is dropped: instr_valid<=0.
- Jump coinciding with a handshake (jump_en && instr_valid && instr_ready in the same cycle): the transfer counts as completed, then the jump applies. The next word is fetched from jump_addr.
- jump_en while already in ISSUE restarts the full ROM_LAT+1 wait at the new address.
- rst mid-ISSUE or mid-HOLD: the word is lost and no instr_valid pulse follows; fetch restarts from RESET_PC.
- rom_data is sampled only on the capture edge; its value at any other time is ignored.

Optional Feature:
- Macro IFETCH_HALT_DETECT_EN.
- Defined: a captured word equal to 16'hFFFF is not presented. instr_valid stays 0, pc is not incremented, instr<=16'hFFFF, state goes to HALT, and halted=1 from the next cycle.
- Undefined: 16'hFFFF is delivered as an ordinary instruction, the HALT state is not built, and halted is tied to 0.

Test Plan:
- Reset then ready=1, ROM word 16'h007F at addresses 1..4 -> instr_valid pulses on cycles 3, 7, 11, 15 after reset release with instr_pc=1, 2, 3, 4 and instr=16'h007F; rom_cs/oe high exactly 3 cycles per fetch.
- Hold ready=0 for 10 cycles after the first valid -> instr and instr_pc=1 stable, rom_cs=0 throughout, pc not advanced; ready=1 -> the next fetch is address 2.
- jump_en with jump_addr=8'h40 during cycle 2 of ISSUE -> abandoned word never presented; the next valid has instr_pc=8'h40 exactly 3 cycles after the jump.
- Jump to 8'hFF and accept the word -> the next fetch has rom_addr=8'h00 and instr_pc=8'h00.
- IFETCH_HALT_DETECT_EN defined, ROM returns 16'hFFFF at address 8'h8A -> no valid for that word, halted=1, rom_cs=0; jump_en to 8'h01 -> halted=0 and fetch resumes at 1. With the macro undefined, the same stimulus gives instr=16'hFFFF, valid=1, halted=0.
- rst asserted while in HOLD with instr_valid=1 -> the next cycle shows instr_valid=0 and instr=16'hFFFF; the first fetch after release is at RESET_PC=1.

Source files
------------

// File: rtl/instr_fetch.sv
// Program counter / instruction fetch stage sitting in front of the program ROM.
// Optional halt-word detection is built when IFETCH_HALT_DETECT_EN is defined.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ROM_LAT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  localparam int unsigned      CNT_W    = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    HOLD  = 2'd1
`ifdef IFETCH_HALT_DETECT_EN
    , HALT = 2'd2
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  cnt;

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Select is decoded from the state so the ROM sees the address from the very
  // first cycle out of reset; reset itself masks it.
  assign rom_cs = (state == ISSUE) && !rst;
  assign rom_oe = rom_cs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      rom_addr    <= RESET_PC;
      cnt         <= '0;
      instr       <= '1;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
      halted_q    <= 1'b0;
`endif
    end else if (jump_en) begin
      // A handshake in this cycle has already completed; any word held or
      // in flight is dropped and fetch restarts at the target.
      state       <= ISSUE;
      pc          <= jump_addr;
      rom_addr    <= jump_addr;
      cnt         <= '0;
      instr_valid <= 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ISSUE: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef IFETCH_HALT_DETECT_EN
            if (rom_data == '1) begin
              instr    <= '1;
              halted_q <= 1'b1;
              state    <= HALT;
            end else
`endif
            begin
              instr       <= rom_data;
              instr_pc    <= pc;
              pc          <= pc + ADDR_W'(1);
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            cnt         <= '0;
            rom_addr    <= pc;
            state       <= ISSUE;
          end
        end
`ifdef IFETCH_HALT_DETECT_EN
        HALT: state <= HALT;
`endif
        default: state <= ISSUE;
      endcase
    end
  end

endmodule
